// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the frame-atomic stream arbiter.
package axis_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DROP  = 2'd2
  } arb_state_t;

  // tuser value stamped on the closing beat of a truncated frame
  localparam logic TRUNC_USER = 1'b1;

  // Width of a source index; never narrower than one bit
  function automatic int unsigned src_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: first requester at or after rr_ptr, scanning upward circularly.
module rr_priority_encoder
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned IDX_W  = src_idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  int unsigned idx;

  // Scan every source once starting at the pointer; the first hit wins
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!any_req && req[idx[IDX_W-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-atomic round-robin merge of NUM_SRC AXI-Stream sources with a beat limit.
module axis_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC         = 4,
  parameter int unsigned AXI_DATA_WIDTH  = 8,
  parameter int unsigned MAX_FRAME_BEATS = 1518
) (
  input  logic                              s_aclk,
  input  logic                              s_sresetn,
  input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]                s_axis_tvalid,
  input  logic [NUM_SRC-1:0]                s_axis_tlast,
  input  logic [NUM_SRC-1:0]                s_axis_tuser,
  output logic [NUM_SRC-1:0]                s_axis_trdy,
  output logic [AXI_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  input  logic                              m_axis_trdy,
  output logic [$clog2(NUM_SRC)-1:0]        grant_id,
  output logic                              busy,
  output logic                              trunc_pulse
);

  localparam int unsigned IDX_W = src_idx_w(NUM_SRC);
  localparam int unsigned CNT_W = $clog2(MAX_FRAME_BEATS + 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    next_ptr;
  logic                any_req;
  logic [CNT_W-1:0]    beat_cnt;
  logic                user_sticky;
  logic                load_en;
  logic                at_limit;
  logic                sel_valid;
  logic                sel_last;
  logic                sel_user;
  logic [AXI_DATA_WIDTH-1:0] sel_data;
  logic                grant_accept;
  logic                frame_end;
  logic                trunc;

  rr_priority_encoder #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_enc (
    .req     (s_axis_tvalid),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign load_en   = ~m_axis_tvalid | m_axis_trdy;
  assign at_limit  = (beat_cnt == CNT_W'(MAX_FRAME_BEATS - 1));
  assign sel_valid = s_axis_tvalid[grant_id];
  assign sel_last  = s_axis_tlast[grant_id];
  assign sel_user  = s_axis_tuser[grant_id];
  assign sel_data  = s_axis_tdata[grant_id*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign next_ptr  = (32'(grant_id) == NUM_SRC - 1) ? '0 : grant_id + 1'b1;
  assign busy      = (state_q != IDLE);

  // State register
  always_ff @(posedge s_aclk or negedge s_sresetn) begin
    if (!s_sresetn) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state, per-source ready and beat-acceptance strobes
  always_comb begin
    state_d      = state_q;
    s_axis_trdy  = '0;
    grant_accept = 1'b0;
    frame_end    = 1'b0;
    trunc        = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = GRANT;
      end
      GRANT: begin
        s_axis_trdy[grant_id] = load_en;
        if (load_en && sel_valid) begin
          grant_accept = 1'b1;
          // tlast on the limit beat is a legal frame, so it is tested first
          if (sel_last) begin
            state_d   = IDLE;
            frame_end = 1'b1;
          end else if (at_limit) begin
            state_d = DROP;
            trunc   = 1'b1;
          end
        end
      end
      DROP: begin
        s_axis_trdy[grant_id] = 1'b1;
        if (sel_valid && sel_last) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, round-robin pointer, beat counter and sticky bad-frame flag
  always_ff @(posedge s_aclk or negedge s_sresetn) begin
    if (!s_sresetn) begin
      grant_id    <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      user_sticky <= 1'b0;
      trunc_pulse <= 1'b0;
    end else begin
      trunc_pulse <= trunc;
      if (state_q == IDLE && any_req) begin
        grant_id    <= winner;
        beat_cnt    <= '0;
        user_sticky <= 1'b0;
      end
      if (grant_accept) begin
        if (beat_cnt != CNT_W'(MAX_FRAME_BEATS)) beat_cnt <= beat_cnt + 1'b1;
        user_sticky <= user_sticky | sel_user;
      end
      if (frame_end) rr_ptr <= next_ptr;
    end
  end

  // Output register: loads only when empty or drained, holds while stalled
  always_ff @(posedge s_aclk or negedge s_sresetn) begin
    if (!s_sresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (load_en) begin
      m_axis_tvalid <= grant_accept;
      if (grant_accept) begin
        m_axis_tdata <= sel_data;
        m_axis_tlast <= sel_last | trunc;
        m_axis_tuser <= sel_user | user_sticky | (trunc & TRUNC_USER);
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Self-checking bench for axis_frame_arbiter: directed scenarios plus random traffic vs a frame-level model.
module tb_axis_frame_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned MAX = 1518;
  localparam int unsigned BUDGET = 20000;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N*W-1:0]   s_axis_tdata;
  logic [N-1:0]     s_axis_tvalid;
  logic [N-1:0]     s_axis_tlast;
  logic [N-1:0]     s_axis_tuser;
  logic [N-1:0]     s_axis_trdy;
  logic [W-1:0]     m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tuser;
  logic             m_axis_trdy;
  logic [$clog2(N)-1:0] grant_id;
  logic             busy;
  logic             trunc_pulse;

  always #5 clk = ~clk;

  axis_frame_arbiter #(
    .NUM_SRC         (N),
    .AXI_DATA_WIDTH  (W),
    .MAX_FRAME_BEATS (MAX)
  ) dut (
    .s_aclk        (clk),
    .s_sresetn     (rstn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_trdy   (s_axis_trdy),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_trdy   (m_axis_trdy),
    .grant_id      (grant_id),
    .busy          (busy),
    .trunc_pulse   (trunc_pulse)
  );

  typedef struct { logic [W-1:0] data; logic last; logic user; } beat_t;
  typedef struct { logic [W-1:0] data; logic last; logic user; logic first; } exp_t;

  beat_t       srcq [N][$];
  exp_t        exp_q[$];
  int unsigned n_checks  = 0;
  int unsigned n_fail    = 0;
  int unsigned model_ptr = 0;
  int unsigned exp_trunc = 0;

  // Append one frame of random data to source s; user_at is the 1-based beat carrying tuser (0 = none)
  task automatic add_frame(input int unsigned s, input int unsigned len, input int unsigned user_at);
    beat_t b;
    for (int unsigned i = 0; i < len; i++) begin
      b.data = W'($urandom);
      b.last = (i == len - 1);
      b.user = (user_at == i + 1);
      srcq[s].push_back(b);
    end
  endtask

  // Frame-level reference: round-robin over sources holding frames, truncate past MAX beats, sticky tuser
  task automatic build_model();
    beat_t       tmp [N][$];
    beat_t       b;
    exp_t        e;
    int          s;
    int unsigned n;
    logic        sticky, first, done;
    exp_q.delete();
    exp_trunc = 0;
    for (int unsigned i = 0; i < N; i++) tmp[i] = srcq[i];
    forever begin
      s = -1;
      for (int unsigned k = 0; k < N; k++)
        if (s < 0 && tmp[(model_ptr + k) % N].size() > 0) s = int'((model_ptr + k) % N);
      if (s < 0) break;
      n = 0; sticky = 0; first = 1; done = 0;
      while (!done) begin
        b = tmp[s].pop_front();
        sticky = sticky | b.user;
        if (n < MAX) begin
          e.data = b.data; e.user = sticky; e.last = b.last; e.first = first;
          first = 0;
          if (n == MAX - 1 && !b.last) begin
            e.last = 1; e.user = 1; exp_trunc++;
          end
          exp_q.push_back(e);
        end
        n++;
        done = b.last;
      end
      model_ptr = (int'(s) + 1) % N;
    end
  endtask

  task automatic drive_sources();
    for (int unsigned i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        s_axis_tdata[i*W +: W] = srcq[i][0].data;
        s_axis_tlast[i]        = srcq[i][0].last;
        s_axis_tuser[i]        = srcq[i][0].user;
      end else begin
        s_axis_tdata[i*W +: W] = '0;
        s_axis_tlast[i]        = 1'b0;
        s_axis_tuser[i]        = 1'b0;
      end
    end
  endtask

  // Play queued frames through the DUT; mode 0: sink always ready, 1: random, 2: ready pattern 1,0,0,1
  task automatic run_frames(input int unsigned mode, input bit gapchk, input bit stallchk, input string name);
    logic [N-1:0] hs;
    logic         stalled_prev = 0;
    logic [W-1:0] prev_data = '0;
    logic         done = 0;
    logic         have_last = 0;
    logic         pending;
    int unsigned  cyc = 0, last_cyc = 0, phase = 0, trunc_seen = 0;
    beat_t        b;
    exp_t         e;
    build_model();
    @(posedge clk); #1;
    for (int unsigned i = 0; i < N; i++) s_axis_tvalid[i] = (srcq[i].size() > 0);
    drive_sources();
    m_axis_trdy = 1'b1;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (stalled_prev) begin
        n_checks++;
        if (!(m_axis_tvalid === 1'b1 && m_axis_tdata === prev_data)) begin
          n_fail++;
          $display("FAIL %s stall_hold: valid=%b data=%h required valid=1 data=%h", name, m_axis_tvalid, m_axis_tdata, prev_data);
        end
      end
      if (stallchk && m_axis_tvalid && !m_axis_trdy) begin
        n_checks++;
        if (s_axis_trdy !== '0) begin
          n_fail++;
          $display("FAIL %s stall_trdy: s_axis_trdy=%b required 0", name, s_axis_trdy);
        end
      end
      if (m_axis_tvalid && m_axis_trdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_beat: got data=%h last=%b user=%b required no beat", name, m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.data || m_axis_tlast !== e.last || m_axis_tuser !== e.user) begin
            n_fail++;
            $display("FAIL %s beat: got data=%h last=%b user=%b required data=%h last=%b user=%b",
                     name, m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user);
          end
          if (gapchk && e.first && have_last) begin
            n_checks++;
            if (cyc - last_cyc != 2) begin
              n_fail++;
              $display("FAIL %s frame_gap: got %0d cycles between frames required 2", name, cyc - last_cyc);
            end
          end
          if (e.last) begin
            last_cyc  = cyc;
            have_last = 1;
          end
        end
      end
      stalled_prev = m_axis_tvalid && !m_axis_trdy;
      prev_data    = m_axis_tdata;
      if (trunc_pulse) trunc_seen++;
      hs = s_axis_tvalid & s_axis_trdy;
      pending = 0;
      for (int unsigned i = 0; i < N; i++) if (srcq[i].size() > 0) pending = 1;
      if (!pending && exp_q.size() == 0 && !m_axis_tvalid && !busy) done = 1;
      if (!done) begin
        @(posedge clk); #1;
        for (int unsigned i = 0; i < N; i++) begin
          if (hs[i]) begin
            b = srcq[i].pop_front();
            if (srcq[i].size() == 0)  s_axis_tvalid[i] = 1'b0;
            else if (b.last)          s_axis_tvalid[i] = 1'b1;
            else                      s_axis_tvalid[i] = (mode == 1) ? (($urandom % 4) != 0) : 1'b1;
          end else if (!s_axis_tvalid[i] && srcq[i].size() > 0) begin
            s_axis_tvalid[i] = (mode == 1) ? ($urandom % 2 == 1) : 1'b1;
          end
        end
        drive_sources();
        phase++;
        case (mode)
          1:       m_axis_trdy = ($urandom % 3) != 0;
          2:       m_axis_trdy = (phase % 4 == 0) || (phase % 4 == 3);
          default: m_axis_trdy = 1'b1;
        endcase
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: %0d beats still expected after %0d cycles, required 0", name, exp_q.size(), cyc);
    end
    n_checks++;
    if (trunc_seen != exp_trunc) begin
      n_fail++;
      $display("FAIL %s trunc_count: got %0d pulses required %0d", name, trunc_seen, exp_trunc);
    end
    s_axis_tvalid = '0;
    m_axis_trdy   = 1'b1;
    for (int unsigned i = 0; i < N; i++) srcq[i].delete();
  endtask

  task automatic do_reset();
    rstn          = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    s_axis_tdata  = '0;
    m_axis_trdy   = 1'b1;
    for (int unsigned i = 0; i < N; i++) srcq[i].delete();
    model_ptr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, trunc_pulse} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid/last/user/busy/trunc=%b required 00000",
               {m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, trunc_pulse});
    end
    n_checks++;
    if (s_axis_trdy !== '0 || grant_id !== '0) begin
      n_fail++;
      $display("FAIL reset_grant: s_axis_trdy=%b grant_id=%0d required 0 and 0", s_axis_trdy, grant_id);
    end
    rstn = 1'b1;
  endtask

  // Src0 alone sends A0..A3: first output two cycles after tvalid, grant_id=0
  task automatic test_single_frame();
    logic [W-1:0] a [4];
    a[0] = 8'hA0; a[1] = 8'hA1; a[2] = 8'hA2; a[3] = 8'hA3;
    @(posedge clk); #1;
    s_axis_tvalid[0] = 1'b1; s_axis_tdata[0 +: W] = a[0]; s_axis_tlast[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: valid=%b busy=%b required 0 0", m_axis_tvalid, busy);
    end
    @(negedge clk);
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b1 || grant_id !== 0 || s_axis_trdy !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_grant: valid=%b busy=%b grant=%0d trdy=%b required 0 1 0 0001",
               m_axis_tvalid, busy, grant_id, s_axis_trdy);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin
        s_axis_tdata[0 +: W] = a[k+1];
        s_axis_tlast[0]      = (k + 1 == 3);
      end else begin
        s_axis_tvalid[0] = 1'b0;
        s_axis_tlast[0]  = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== a[k] || m_axis_tlast !== (k == 3)) begin
        n_fail++;
        $display("FAIL single_beat%0d: valid=%b data=%h last=%b required 1 %h %b",
                 k, m_axis_tvalid, m_axis_tdata, m_axis_tlast, a[k], (k == 3));
      end
    end
    @(negedge clk);
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: valid=%b busy=%b required 0 0", m_axis_tvalid, busy);
    end
    model_ptr = 1;
  endtask

  task automatic test_back_to_back();
    for (int unsigned i = 0; i < N; i++) add_frame(i, 2, 0);
    run_frames(0, 1'b1, 1'b0, "back_to_back");
  endtask

  task automatic test_truncation();
    add_frame(1, 2000, 0);
    add_frame(2, 3, 0);
    add_frame(0, MAX, 0);
    run_frames(0, 1'b0, 1'b0, "truncation");
  endtask

  task automatic test_tuser_sticky();
    add_frame(2, 6, 3);
    run_frames(0, 1'b0, 1'b0, "tuser_sticky");
  endtask

  task automatic test_stall();
    add_frame(3, 8, 0);
    add_frame(0, 5, 0);
    run_frames(2, 1'b0, 1'b1, "stall");
  endtask

  // Reset after five accepted beats of a 10-beat frame on src2, then check the pointer restarted at 0
  task automatic test_reset_mid_frame();
    @(posedge clk); #1;
    s_axis_tvalid[2] = 1'b1; s_axis_tdata[2*W +: W] = 8'hD0; s_axis_tlast[2] = 1'b0;
    @(posedge clk);
    for (int unsigned k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      s_axis_tdata[2*W +: W] = 8'hD0 + W'(k + 1);
    end
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || grant_id !== 2 || m_axis_tdata !== 8'hD4) begin
      n_fail++;
      $display("FAIL midreset_pre: valid=%b grant=%0d data=%h required 1 2 d4", m_axis_tvalid, grant_id, m_axis_tdata);
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_trdy !== '0 || busy !== 1'b0 || grant_id !== 0) begin
      n_fail++;
      $display("FAIL midreset_async: valid=%b trdy=%b busy=%b grant=%0d required 0 0 0 0",
               m_axis_tvalid, s_axis_trdy, busy, grant_id);
    end
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    @(negedge clk);
    rstn = 1'b1;
    model_ptr = 0;
    add_frame(3, 4, 0);
    add_frame(1, 4, 0);
    run_frames(0, 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    int unsigned len;
    for (int unsigned r = 0; r < 12; r++) begin
      for (int unsigned s = 0; s < N; s++) begin
        for (int unsigned f = $urandom_range(0, 3); f > 0; f--) begin
          len = $urandom_range(1, 12);
          add_frame(s, len, ($urandom % 4 == 0) ? $urandom_range(1, len) : 0);
        end
      end
      run_frames(1, 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_truncation();
    test_tuser_sticky();
    test_stall();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
- Frame-atomic round-robin arbiter.
- Merges NUM_SRC AXI-Stream frame sources (e.g. UDP, ARP, ICMP TX paths) into the single write-side stream of the async packet FIFO.
- Never interleaves beats of different frames.
- Enforces a maximum frame length: oversize frames are truncated and marked bad via tuser, so the FIFO discards them uncommitted.

Parameters:
- NUM_SRC, 4, number of input sources (2..8).
- AXI_DATA_WIDTH, 8, tdata width of all streams.
- MAX_FRAME_BEATS, 1518, beats allowed per frame before forced truncation.

Ports:
- s_aclk  in  1  clock, shared with the FIFO write domain
- s_sresetn  in  1  reset
- s_axis_tdata  in  NUM_SRC*AXI_DATA_WIDTH  source data; source i occupies slice i
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tlast  in  NUM_SRC  per-source last
- s_axis_tuser  in  NUM_SRC  per-source bad-frame flag
- s_axis_trdy  out  NUM_SRC  per-source ready
- m_axis_tdata  out  AXI_DATA_WIDTH  merged data to FIFO
- m_axis_tvalid  out  1  merged valid
- m_axis_tlast  out  1  merged last
- m_axis_tuser  out  1  merged bad-frame flag
- m_axis_trdy  in  1  FIFO ready
- grant_id  out  $clog2(NUM_SRC)  currently/last granted source
- busy  out  1  high in GRANT or DROP state
- trunc_pulse  out  1  one-cycle pulse per truncated frame

Behaviour:
- Reset and clocking:
  - Reset is s_sresetn, asynchronous, active-low; clock is s_aclk.
  - All state clears immediately on reset assertion: state=IDLE, rr_ptr=0, beat_cnt=0.
  - Output reset values: m_axis_tvalid=0, tlast=0, tuser=0, s_axis_trdy=0, grant_id=0, busy=0, trunc_pulse=0.
- Output register:
  - Single registered stage; 1-cycle latency from input acceptance to m_axis_* valid.
  - load_en = ~m_axis_tvalid | m_axis_trdy.
  - m_axis_tvalid holds, and data is stable, while m_axis_trdy=0.
- State machine, states IDLE, GRANT, DROP:
  - IDLE:
    - s_axis_trdy=0.
    - If any tvalid is set, pick the first requester at or after rr_ptr, scanning circularly upward.
    - Next cycle: grant_id=winner, state=GRANT, beat_cnt=0.
    - Arbitration costs exactly 1 idle cycle per frame.
  - GRANT:
    - s_axis_trdy[grant_id]=load_en; all other bits 0.
    - Accepted beat: copied to the output register; beat_cnt+1.
    - Accepted beat with tlast=1: state=IDLE, rr_ptr=grant_id+1 mod NUM_SRC.
    - Accepted beat with beat_cnt==MAX_FRAME_BEATS-1 and tlast=0: output beat gets tlast=1, tuser=1; trunc_pulse=1 next cycle; state=DROP.
    - Source tuser is passed through per beat, and is sticky until end of frame (once seen, every later beat of the frame carries tuser=1).
  - DROP:
    - s_axis_trdy[grant_id]=1 regardless of m_axis_trdy.
    - Beats are discarded; the output register is not loaded.
    - On accepted tlast: IDLE, rr_ptr=grant_id+1.
- Fairness and saturation:
  - A source deasserting tvalid mid-frame holds the grant; no timeout other than the beat limit.
  - No source is starved: worst-case wait is (NUM_SRC-1) full frames.
  - beat_cnt saturates; it never wraps.
- Simultaneous events:
  - tlast arriving on beat MAX_FRAME_BEATS is a legal frame, not truncated.
  - Other sources' tvalid during GRANT/DROP is ignored until IDLE.
- Reset mid-frame:
  - The output frame is abandoned without tlast.
  - The sink shares s_sresetn, so its uncommitted partial frame is discarded with it.

Decomposition:
- Package axis_arb_pkg:
  - state enum {IDLE, GRANT, DROP};
  - function for the SRC_IDX_W width;
  - constant TRUNC_USER=1'b1.
- Sub-module rr_priority_encoder (NUM_SRC): request vector + rr_ptr -> winner index + any_req, purely combinational.

Test Plan:
- Src0 only sends a 4-beat frame A0..A3 with m_axis_trdy=1 -> output A0..A3, tlast on A3, first output 2 cycles after tvalid, grant_id=0.
- Src0..3 each hold a 2-beat frame simultaneously -> output order src0, src1, src2, src3, each frame contiguous, 1 gap cycle between frames.
- Src1 sends a 2000-beat frame with MAX_FRAME_BEATS=1518 -> 1518 beats output, beat 1518 has tlast=1 and tuser=1; trunc_pulse once; remaining 482 beats consumed with no output; next grant starts afterwards.
- Src2 frame where tuser=1 on beat 3 of 6 -> output beats 3..6 carry tuser=1, tlast on beat 6.
- m_axis_trdy toggles 1,0,0,1 repeatedly during a frame -> no beat lost or duplicated, data stable while stalled, s_axis_trdy low during stall.
- s_sresetn asserted at beat 5 of a 10-beat frame -> m_axis_tvalid=0 and s_axis_trdy=0 immediately; after release, state IDLE, rr_ptr=0.
